pet_state_engine: RTL
=====================

# pet_state_engine

Upstream producer for the LCD1602 controller: holds the pet's food, joy and energy levels and derives the face index the display stage renders. Consumes one-cycle, already-debounced button pulses (feed, play, sleep) and an internal time base. Stats decay over time, and the face index is computed from stats, mode and recent actions. Outputs connect directly to the controller's `face`, `food_value`, `joy_value` and `energy_value` inputs.

## Interface
- `MAX_VALUE`, 5: stat ceiling; stats range 0..MAX_VALUE
- `NUM_FACES`, 9: number of face codes; fixed at 9 by the face map
- `TICK_CYCLES`, 50_000_000: clocks per game tick
- `FOOD_DECAY`, 4: ticks per food decrement
- `JOY_DECAY`, 3: ticks per joy decrement
- `ENERGY_DECAY`, 5: ticks per energy decrement while awake
- `SLEEP_GAIN`, 2: ticks per energy increment while asleep
- `REACT_TICKS`, 2: ticks the eating/playing face is held
- `DEATH_TICKS`, 6: consecutive ticks with food==0 before death
- `clk`, in, 1: single clock
- `reset`, in, 1: asynchronous, active-low
- `btn_feed`, in, 1: one-cycle pulse
- `btn_play`, in, 1: one-cycle pulse
- `btn_sleep`, in, 1: one-cycle pulse
- `face`, out, $clog2(NUM_FACES): face code
- `food_value`, out, $clog2(MAX_VALUE+1): food level
- `joy_value`, out, $clog2(MAX_VALUE+1): joy level
- `energy_value`, out, $clog2(MAX_VALUE+1): energy level

## Operation
- Modes: AWAKE, SLEEP, DEAD.
- Reset (reset=0): all stats = MAX_VALUE, face = 0, mode AWAKE, all counters = 0.
- Tick: one-cycle pulse every TICK_CYCLES clocks.
- Per-stat divider counters advance on each tick.
- When a stat's divider wraps, that stat gets a decrement, or in SLEEP an energy increment.
- Joy and food decay in both AWAKE and SLEEP.
- Buttons, AWAKE only except sleep.
  - Priority when pulses coincide: sleep > feed > play. Lower-priority pulses that cycle are dropped.
  - feed: food +1, starts EAT reaction.
  - play: joy +1, energy −1, starts PLAY reaction. Ignored if energy==0.
  - sleep: toggles AWAKE↔SLEEP and clears any reaction.
  - feed and play are ignored in SLEEP.
- Auto-wake: SLEEP→AWAKE in the same cycle energy reaches MAX_VALUE.
- Update arithmetic:
  - Same-cycle button and decay on one stat: new = old + inc − dec, computed at one bit wider.
  - Result saturates to 0..MAX_VALUE.
- Death:
  - Starvation counter increments on each tick with food==0 and clears when food>0.
  - Reaching DEATH_TICKS enters DEAD.
  - DEAD is terminal until reset: stats freeze and buttons are ignored.
- Reaction timer: loaded with REACT_TICKS on an accepted feed/play and decremented per tick. A new accepted press reloads the timer and replaces the reaction type.
- Face, first match wins:
  - DEAD→8
  - SLEEP→5
  - EAT reaction→6
  - PLAY reaction→7
  - energy≤1→4 (tired)
  - food≤1→2 (hungry)
  - joy≤1→3 (sad)
  - all stats ≥MAX_VALUE−1→0 (happy)
  - otherwise→1 (neutral)

## Timing
- All outputs are registered.
- Button pulse at edge N → stat change visible after edge N+1. Face reflects the new stats one cycle later (N+2).
- First tick occurs TICK_CYCLES cycles after reset deassertion.
- A button pulse and a tick in the same cycle are both applied in that cycle.
- Reset asserted mid-operation forces reset values immediately, asynchronously. Counters restart from 0 on release.
- Held (multi-cycle) button levels are not supported. Each high cycle counts as a press.

## Structure
- Shared package `pet_pkg` holds:
  - face code localparams FACE_HAPPY=0 … FACE_DEAD=8
  - mode encoding (AWAKE/SLEEP/DEAD)
  - reaction encoding (NONE/EAT/PLAY)
- The controller uses the same face constants.
- One sub-module: `tick_gen`, a TICK_CYCLES prescaler emitting a one-cycle `tick` with async active-low reset.
- Stat update logic and face priority encoder live in the top module.

## Test plan
Bench uses TICK_CYCLES=4 and default decay parameters.
- Reset released, no buttons, 12 ticks → food 2, joy 1, energy 3; face 3 (sad; energy 3 and food 2 are not low, joy 1 is).
- btn_feed with food=5 → food stays 5, face 6 for 2 ticks, then back to the stat-derived face.
- Energy 0 AWAKE, btn_play → ignored: joy and energy unchanged, face 4.
- btn_sleep at energy 3 → face 5; energy 4 after 2 ticks, 5 after 4 ticks; auto-wake to AWAKE the same cycle energy hits 5.
- btn_feed+btn_sleep same cycle → only sleep takes effect, food unchanged.
- No feeding until food==0 for 6 ticks → face 8, stats frozen, buttons ignored. Reset low then high → stats 5/5/5, face 0.

Source files
------------

// File: rtl/pet_pkg.sv
// Shared pet constants: face codes (also used by the LCD controller), mode and reaction encodings.
package pet_pkg;

  localparam int FACE_HAPPY   = 0;
  localparam int FACE_NEUTRAL = 1;
  localparam int FACE_HUNGRY  = 2;
  localparam int FACE_SAD     = 3;
  localparam int FACE_TIRED   = 4;
  localparam int FACE_SLEEP   = 5;
  localparam int FACE_EAT     = 6;
  localparam int FACE_PLAY    = 7;
  localparam int FACE_DEAD    = 8;

  typedef enum logic [1:0] {
    MODE_AWAKE = 2'd0,
    MODE_SLEEP = 2'd1,
    MODE_DEAD  = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    REACT_NONE = 2'd0,
    REACT_EAT  = 2'd1,
    REACT_PLAY = 2'd2
  } react_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pet_state_engine_tick_gen.sv
// Game time base: one-cycle tick_o every TICK_CYCLES clocks, first one TICK_CYCLES cycles after reset release.
module tick_gen #(
  parameter int TICK_CYCLES = 50_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CW'(TICK_CYCLES - 1));

  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pet_state_engine.sv
// Pet stat engine: buttons and tick decay update stats one edge after the pulse; face follows one edge later.
module pet_state_engine
  import pet_pkg::*;
#(
  parameter int MAX_VALUE    = 5,
  parameter int NUM_FACES    = 9,
  parameter int TICK_CYCLES  = 50_000_000,
  parameter int FOOD_DECAY   = 4,
  parameter int JOY_DECAY    = 3,
  parameter int ENERGY_DECAY = 5,
  parameter int SLEEP_GAIN   = 2,
  parameter int REACT_TICKS  = 2,
  parameter int DEATH_TICKS  = 6
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           btn_feed,
  input  logic                           btn_play,
  input  logic                           btn_sleep,
  output logic [$clog2(NUM_FACES)-1:0]   face,
  output logic [$clog2(MAX_VALUE+1)-1:0] food_value,
  output logic [$clog2(MAX_VALUE+1)-1:0] joy_value,
  output logic [$clog2(MAX_VALUE+1)-1:0] energy_value
);

  localparam int SW = $clog2(MAX_VALUE + 1);
  localparam int FW = $clog2(NUM_FACES);
  localparam int CW = $clog2(max_int(max_int(max_int(FOOD_DECAY, JOY_DECAY),
                                             max_int(ENERGY_DECAY, SLEEP_GAIN)),
                                     max_int(REACT_TICKS, DEATH_TICKS)) + 1);

  // old + inc - dec in signed SW+1 bits, then clamp to 0..MAX_VALUE
  function automatic logic [SW-1:0] sat_upd(input logic [SW-1:0] old_v,
                                            input logic          inc,
                                            input logic [1:0]    dec);
    logic signed [SW:0] sum;
    sum = $signed({1'b0, old_v}) + $signed({{SW{1'b0}}, inc})
        - $signed({{(SW-1){1'b0}}, dec});
    if (sum < 0)                                return '0;
    else if (sum > $signed((SW+1)'(MAX_VALUE))) return SW'(MAX_VALUE);
    else                                        return sum[SW-1:0];
  endfunction

  logic tick;

  mode_e          mode_q, mode_d;
  react_e         react_q, react_d;
  logic [CW-1:0]  react_cnt_q, react_cnt_d;
  logic [CW-1:0]  food_div_q, food_div_d;
  logic [CW-1:0]  joy_div_q, joy_div_d;
  logic [CW-1:0]  energy_div_q, energy_div_d;
  logic [CW-1:0]  starve_q, starve_d;
  logic [SW-1:0]  food_q, food_d;
  logic [SW-1:0]  joy_q, joy_d;
  logic [SW-1:0]  energy_q, energy_d;
  logic [FW-1:0]  face_q, face_d;

  logic          alive, awake;
  logic          accept_sleep, accept_feed, accept_play;
  logic          food_wrap, joy_wrap, energy_wrap, energy_gain;
  logic [CW-1:0] energy_lim;
  logic [1:0]    energy_dec;

  tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_gen (
    .clk_i (clk),
    .rst_ni(reset),
    .tick_o(tick)
  );

  always_comb begin
    mode_d       = mode_q;
    react_d      = react_q;
    react_cnt_d  = react_cnt_q;
    food_div_d   = food_div_q;
    joy_div_d    = joy_div_q;
    energy_div_d = energy_div_q;
    starve_d     = starve_q;
    food_d       = food_q;
    joy_d        = joy_q;
    energy_d     = energy_q;
    food_wrap    = 1'b0;
    joy_wrap     = 1'b0;
    energy_wrap  = 1'b0;
    energy_gain  = 1'b0;
    energy_lim   = CW'(ENERGY_DECAY);
    energy_dec   = 2'd0;

    alive = (mode_q != MODE_DEAD);
    awake = (mode_q == MODE_AWAKE);

    // sleep > feed > play; losers of a coincident pulse are simply dropped
    accept_sleep = alive && btn_sleep;
    accept_feed  = awake && !btn_sleep && btn_feed;
    accept_play  = awake && !btn_sleep && !btn_feed && btn_play && (energy_q != '0);

    if (alive) begin
      if (tick) begin
        food_wrap  = (food_div_q == CW'(FOOD_DECAY - 1));
        food_div_d = food_wrap ? '0 : food_div_q + CW'(1);
        joy_wrap   = (joy_div_q == CW'(JOY_DECAY - 1));
        joy_div_d  = joy_wrap ? '0 : joy_div_q + CW'(1);
        energy_lim   = (mode_q == MODE_SLEEP) ? CW'(SLEEP_GAIN) : CW'(ENERGY_DECAY);
        energy_wrap  = (energy_div_q == energy_lim - CW'(1));
        energy_div_d = energy_wrap ? '0 : energy_div_q + CW'(1);
      end
      energy_gain = energy_wrap && (mode_q == MODE_SLEEP);
      energy_dec  = {1'b0, energy_wrap && awake} + {1'b0, accept_play};

      food_d   = sat_upd(food_q, accept_feed, {1'b0, food_wrap});
      joy_d    = sat_upd(joy_q, accept_play, {1'b0, joy_wrap});
      energy_d = sat_upd(energy_q, energy_gain, energy_dec);

      if (food_q != '0) starve_d = '0;
      else if (tick)    starve_d = starve_q + CW'(1);

      if (accept_sleep) begin
        react_d     = REACT_NONE;
        react_cnt_d = '0;
      end else if (accept_feed) begin
        react_d     = REACT_EAT;
        react_cnt_d = CW'(REACT_TICKS);
      end else if (accept_play) begin
        react_d     = REACT_PLAY;
        react_cnt_d = CW'(REACT_TICKS);
      end else if (tick && react_cnt_q != '0) begin
        react_cnt_d = react_cnt_q - CW'(1);
        if (react_cnt_q == CW'(1)) react_d = REACT_NONE;
      end
    end

    case (mode_q)
      MODE_AWAKE: if (accept_sleep) mode_d = MODE_SLEEP;
      MODE_SLEEP: if (accept_sleep || (energy_gain && energy_d == SW'(MAX_VALUE)))
                    mode_d = MODE_AWAKE;
      default:    mode_d = mode_q;
    endcase
    if (alive && starve_d == CW'(DEATH_TICKS)) mode_d = MODE_DEAD;

    // energy period differs between modes, so each mode starts a fresh count
    if (mode_d != mode_q) energy_div_d = '0;

    if (mode_q == MODE_DEAD)                  face_d = FW'(FACE_DEAD);
    else if (mode_q == MODE_SLEEP)            face_d = FW'(FACE_SLEEP);
    else if (react_q == REACT_EAT)            face_d = FW'(FACE_EAT);
    else if (react_q == REACT_PLAY)           face_d = FW'(FACE_PLAY);
    else if (energy_q <= SW'(1))              face_d = FW'(FACE_TIRED);
    else if (food_q <= SW'(1))                face_d = FW'(FACE_HUNGRY);
    else if (joy_q <= SW'(1))                 face_d = FW'(FACE_SAD);
    else if (food_q >= SW'(MAX_VALUE - 1) && joy_q >= SW'(MAX_VALUE - 1) &&
             energy_q >= SW'(MAX_VALUE - 1))  face_d = FW'(FACE_HAPPY);
    else                                      face_d = FW'(FACE_NEUTRAL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q       <= MODE_AWAKE;
      react_q      <= REACT_NONE;
      react_cnt_q  <= '0;
      food_div_q   <= '0;
      joy_div_q    <= '0;
      energy_div_q <= '0;
      starve_q     <= '0;
      food_q       <= SW'(MAX_VALUE);
      joy_q        <= SW'(MAX_VALUE);
      energy_q     <= SW'(MAX_VALUE);
      face_q       <= FW'(FACE_HAPPY);
    end else begin
      mode_q       <= mode_d;
      react_q      <= react_d;
      react_cnt_q  <= react_cnt_d;
      food_div_q   <= food_div_d;
      joy_div_q    <= joy_div_d;
      energy_div_q <= energy_div_d;
      starve_q     <= starve_d;
      food_q       <= food_d;
      joy_q        <= joy_d;
      energy_q     <= energy_d;
      face_q       <= face_d;
    end
  end

  assign face         = face_q;
  assign food_value   = food_q;
  assign joy_value    = joy_q;
  assign energy_value = energy_q;

endmodule
